// File: rtl/mcpu_seq_alu_if.sv
// ----------------------------------------------------------------------------
// mcpu_seq_alu_if
//
// Purpose : request/response bundle between the MCPU control path and the
//           sequential ALU. The register file side (master) drives an opcode
//           and two operands with a start strobe. The ALU side (slave) returns
//           busy, a one-cycle done pulse, the 2W-bit result and the
//           carry/zero/divide-by-zero flags.
//
// Signals : start  master->slave  request, taken only while busy is low
//           cmd    master->slave  opcode (CMD_SIZE bits)
//           in1    master->slave  operand A / dividend (WORD_SIZE bits)
//           in2    master->slave  operand B / shift amount / divisor
//           busy   slave->master  multi-cycle operation in progress
//           done   slave->master  one-cycle pulse, result and flags updated
//           out    slave->master  result (2*WORD_SIZE bits), held between dones
//           CF     slave->master  carry flag
//           ZF     slave->master  zero flag (whole 2W result)
//           DZ     slave->master  divide-by-zero flag
// ----------------------------------------------------------------------------
interface mcpu_seq_alu_if #(
    parameter int WORD_SIZE = 16,
    parameter int CMD_SIZE  = 3
);
    logic                   start;
    logic [CMD_SIZE-1:0]    cmd;
    logic [WORD_SIZE-1:0]   in1;
    logic [WORD_SIZE-1:0]   in2;
    logic                   busy;
    logic                   done;
    logic [2*WORD_SIZE-1:0] out;
    logic                   CF;
    logic                   ZF;
    logic                   DZ;

    modport master (
        output start, cmd, in1, in2,
        input  busy, done, out, CF, ZF, DZ
    );

    modport slave (
        input  start, cmd, in1, in2,
        output busy, done, out, CF, ZF, DZ
    );
endinterface

// File: rtl/mcpu_seq_alu.sv
// ----------------------------------------------------------------------------
// mcpu_seq_alu
//
// Purpose : registered, handshaked MCPU ALU. AND/OR/XOR/ADD/LSL/LSR (and DIV
//           by zero) finish one cycle after acceptance. MUL (shift-add) and
//           unsigned DIV (restoring) run for WORD_SIZE iterations on a shared
//           accumulator datapath. Results and flags are registered and change
//           only in the cycle where done is high.
//
// Ports   : clk    rising-edge clock
//           rst_n  synchronous reset, active low; aborts any running operation
//           bus    mcpu_seq_alu_if.slave (start/cmd/in1/in2 in,
//                  busy/done/out/CF/ZF/DZ out)
//
// Opcodes : AND=0 OR=1 XOR=2 ADD=3 LSL=4 LSR=5 MUL=6 DIV=7
//
// Option  : define MCPU_ALU_EARLY_TERM_EN to let MUL finish as soon as the
//           remaining multiplier bits are all zero (latency = 2 + index of the
//           highest set bit of in2, or 1 when in2 is zero). Results are
//           identical in both builds; DIV timing is unaffected.
// ----------------------------------------------------------------------------
module mcpu_seq_alu #(
    parameter int WORD_SIZE = 16,
    parameter int CMD_SIZE  = 3,
    parameter int CNT_SIZE  = $clog2(WORD_SIZE) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mcpu_seq_alu_if.slave bus
);
    localparam int W  = WORD_SIZE;
    localparam int W2 = 2 * WORD_SIZE;

    localparam logic [CMD_SIZE-1:0] OP_AND = CMD_SIZE'(0);
    localparam logic [CMD_SIZE-1:0] OP_OR  = CMD_SIZE'(1);
    localparam logic [CMD_SIZE-1:0] OP_XOR = CMD_SIZE'(2);
    localparam logic [CMD_SIZE-1:0] OP_ADD = CMD_SIZE'(3);
    localparam logic [CMD_SIZE-1:0] OP_LSL = CMD_SIZE'(4);
    localparam logic [CMD_SIZE-1:0] OP_LSR = CMD_SIZE'(5);
    localparam logic [CMD_SIZE-1:0] OP_MUL = CMD_SIZE'(6);
    localparam logic [CMD_SIZE-1:0] OP_DIV = CMD_SIZE'(7);

    // 2W always fits in W bits because W >= 4.
    localparam logic [W-1:0] TWO_W = W'(W2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q;
    logic [CNT_SIZE-1:0] cnt_q;
    logic                is_div_q;
    // Shared iteration datapath:
    //   MUL: acc_q = running product, opa_q = multiplicand shifted left,
    //        opb_q = multiplier shifted right.
    //   DIV: acc_q = {remainder, dividend/quotient} shifted left each step,
    //        opa_q[W-1:0] = divisor; opb_q unused.
    logic [W2-1:0]       acc_q;
    logic [W2-1:0]       opa_q;
    logic [W-1:0]        opb_q;

    logic                busy_q;
    logic                done_q;
    logic [W2-1:0]       out_q;
    logic                cf_q;
    logic                zf_q;
    logic                dz_q;

    // ------------------------------------------------------------------------
    // Single-cycle result, computed straight from the bus at acceptance
    // ------------------------------------------------------------------------
    logic [W:0]      add_sum;
    logic [4*W-1:0]  lsl_wide;
    logic [W:0]      lsr_mask;
    logic [W2-1:0]   fast_out;
    logic            fast_cf;
    logic            fast_dz;
    logic            launch_iter;

    always_comb begin
        add_sum     = {1'b0, bus.in1} + {1'b0, bus.in2};
        // Shift in a 4W-wide field so bits pushed past 2W-1 stay visible
        // for the carry flag.
        lsl_wide    = {{(3*W){1'b0}}, bus.in1} << bus.in2;
        // One-hot pick of in1[in2-1]: {in1,0} bit in2 is in1[in2-1] for
        // 1..W and the mask vanishes for larger shift amounts.
        lsr_mask    = (W+1)'(1) << bus.in2;
        fast_out    = '0;
        fast_cf     = 1'b0;
        fast_dz     = 1'b0;
        launch_iter = 1'b0;
        case (bus.cmd)
            OP_AND: fast_out = {{W{1'b0}}, bus.in1 & bus.in2};
            OP_OR:  fast_out = {{W{1'b0}}, bus.in1 | bus.in2};
            OP_XOR: fast_out = {{W{1'b0}}, bus.in1 ^ bus.in2};
            OP_ADD: begin
                fast_out = {{W{1'b0}}, add_sum[W-1:0]};
                fast_cf  = add_sum[W];
            end
            OP_LSL: begin
                fast_out = lsl_wide[W2-1:0];
                fast_cf  = (bus.in2 >= TWO_W) ? (|bus.in1) : (|lsl_wide[4*W-1:W2]);
            end
            OP_LSR: begin
                fast_out = {{W{1'b0}}, bus.in1 >> bus.in2};
                fast_cf  = |({bus.in1, 1'b0} & lsr_mask);
            end
            OP_MUL: begin
`ifdef MCPU_ALU_EARLY_TERM_EN
                // A zero multiplier has nothing to accumulate: finish now
                // with out=0.
                launch_iter = |bus.in2;
`else
                launch_iter = 1'b1;
`endif
            end
            OP_DIV: begin
                if (bus.in2 == '0) begin
                    fast_out = {bus.in1, {W{1'b1}}};
                    fast_cf  = 1'b1;
                    fast_dz  = 1'b1;
                end else begin
                    launch_iter = 1'b1;
                end
            end
            default: fast_out = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // One iteration step of the shared MUL/DIV datapath
    // ------------------------------------------------------------------------
    logic [W2-1:0] mul_acc_step;
    logic [W:0]    div_trial;
    logic          div_ge;
    logic [W-1:0]  div_rem;
    logic [W2-1:0] div_acc_step;
    logic [W2-1:0] acc_d;
    logic [W2-1:0] opa_d;
    logic [W-1:0]  opb_d;
    logic          iter_last;

    always_comb begin
        mul_acc_step = opb_q[0] ? (acc_q + opa_q) : acc_q;

        // Partial remainder shifted left with the next dividend bit appended;
        // it needs W+1 bits because it can reach 2*divisor-1.
        div_trial = acc_q[W2-1:W-1];
        div_ge    = div_trial >= {1'b0, opa_q[W-1:0]};
        div_rem   = W'(div_trial - {1'b0, opa_q[W-1:0]});
        if (div_ge) begin
            div_acc_step = {div_rem, acc_q[W-2:0], 1'b1};
        end else begin
            div_acc_step = {acc_q[W2-2:0], 1'b0};
        end

        acc_d = is_div_q ? div_acc_step : mul_acc_step;
        opa_d = is_div_q ? opa_q : (opa_q << 1);
        opb_d = opb_q >> 1;

        iter_last = (cnt_q == CNT_SIZE'(1));
`ifdef MCPU_ALU_EARLY_TERM_EN
        // Stop once this step consumes the last set multiplier bit.
        if (!is_div_q && (opb_q[W-1:1] == '0)) begin
            iter_last = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (launch_iter) begin
                            state_q  <= S_ITER;
                            busy_q   <= 1'b1;
                            cnt_q    <= CNT_SIZE'(W);
                            is_div_q <= (bus.cmd == OP_DIV);
                            if (bus.cmd == OP_DIV) begin
                                acc_q <= {{W{1'b0}}, bus.in1};
                                opa_q <= {{W{1'b0}}, bus.in2};
                            end else begin
                                acc_q <= '0;
                                opa_q <= {{W{1'b0}}, bus.in1};
                            end
                            opb_q <= bus.in2;
                        end else begin
                            done_q <= 1'b1;
                            out_q  <= fast_out;
                            cf_q   <= fast_cf;
                            zf_q   <= (fast_out == '0);
                            dz_q   <= fast_dz;
                        end
                    end
                end
                S_ITER: begin
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    cnt_q <= cnt_q - CNT_SIZE'(1);
                    if (iter_last) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= acc_d;
                        cf_q    <= 1'b0;
                        zf_q    <= (acc_d == '0);
                        dz_q    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
    assign bus.CF   = cf_q;
    assign bus.ZF   = zf_q;
    assign bus.DZ   = dz_q;

endmodule

// File: tb/tb_mcpu_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_mcpu_seq_alu
//
// Self-checking bench for mcpu_seq_alu (WORD_SIZE=16). Expected results come
// from a behavioural model built on native operators and from hand-worked
// constants; they are queued when an operation is issued and popped when the
// unit raises done. Latency expectations follow MCPU_ALU_EARLY_TERM_EN when
// the bench is compiled with it.
// ----------------------------------------------------------------------------
module tb_mcpu_seq_alu;
    localparam int W  = 16;
    localparam int W2 = 32;

    localparam logic [2:0] C_AND = 3'd0;
    localparam logic [2:0] C_OR  = 3'd1;
    localparam logic [2:0] C_XOR = 3'd2;
    localparam logic [2:0] C_ADD = 3'd3;
    localparam logic [2:0] C_LSL = 3'd4;
    localparam logic [2:0] C_LSR = 3'd5;
    localparam logic [2:0] C_MUL = 3'd6;
    localparam logic [2:0] C_DIV = 3'd7;

    typedef struct packed {
        logic [W2-1:0] out;
        logic          cf;
        logic          zf;
        logic          dz;
        logic [7:0]    lat;
    } exp_t;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        exp_t          e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    mcpu_seq_alu_if #(.WORD_SIZE(W), .CMD_SIZE(3)) bus ();

    mcpu_seq_alu #(.WORD_SIZE(W), .CMD_SIZE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // ---------------------------------------------------------------- model
    function automatic logic [7:0] mul_lat(input logic [W-1:0] b);
`ifdef MCPU_ALU_EARLY_TERM_EN
        int h;
        h = -1;
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return (h < 0) ? 8'd1 : 8'(h + 2);
`else
        return 8'(W + 1) | (b[0] & 1'b0);
`endif
    endfunction

    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] wide;
        logic [31:0] s;
        e     = '0;
        e.lat = 8'd1;
        case (c)
            C_AND: e.out = {16'h0, a & b};
            C_OR:  e.out = {16'h0, a | b};
            C_XOR: e.out = {16'h0, a ^ b};
            C_ADD: begin
                s     = {16'h0, a} + {16'h0, b};
                e.out = {16'h0, s[15:0]};
                e.cf  = s[16];
            end
            C_LSL: begin
                if (b >= 16'd32) begin
                    e.out = '0;
                    e.cf  = (a != 0);
                end else begin
                    wide  = {48'h0, a} << b;
                    e.out = wide[31:0];
                    e.cf  = (wide[63:32] != 0);
                end
            end
            C_LSR: begin
                e.out = (b >= 16'd16) ? 32'h0 : {16'h0, a >> b};
                if (b >= 16'd1 && b <= 16'd16) e.cf = a[b - 16'd1];
            end
            C_MUL: begin
                e.out = {16'h0, a} * {16'h0, b};
                e.lat = mul_lat(b);
            end
            default: begin
                if (b == 0) begin
                    e.out = {a, 16'hFFFF};
                    e.cf  = 1'b1;
                    e.dz  = 1'b1;
                end else begin
                    e.out = {a % b, a / b};
                    e.lat = 8'(W + 1);
                end
            end
        endcase
        e.zf = (e.out == 0);
        return e;
    endfunction

    // Drive one request and wait (bounded) for done. Called #1 after a
    // rising edge; returns #1 after the edge that produced done.
    task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output bit busy_seen, output bit to);
        bus.cmd   = c;
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        lat       = 0;
        busy_seen = 1'b0;
        to        = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_seen = 1'b1;
        end while (bus.done !== 1'b1 && lat < 100);
        if (bus.done !== 1'b1) to = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.cmd   = '0;
        bus.in1   = '0;
        bus.in2   = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.CF, bus.ZF, bus.DZ} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: busy/done/CF/ZF/DZ=%b required 00000",
                     {bus.busy, bus.done, bus.CF, bus.ZF, bus.DZ});
        end
        total++;
        if (bus.out !== 32'h0) begin
            bad++;
            $display("FAIL reset_out: out=%h required 00000000", bus.out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: busy=%b done=%b out=%h", bus.busy, bus.done, bus.out);
    endtask

    task automatic test_vectors();
        vec_t v[8];
        exp_t e;
        int   lat;
        bit   bs, to;
        v[0] = {C_ADD, 16'hFFFF, 16'h0001, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'd1};
        v[1] = {C_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b0, 8'd17};
`ifdef MCPU_ALU_EARLY_TERM_EN
        v[2] = {C_MUL, 16'hFFFF, 16'h0003, 32'h0002FFFD, 1'b0, 1'b0, 1'b0, 8'd3};
`else
        v[2] = {C_MUL, 16'hFFFF, 16'h0003, 32'h0002FFFD, 1'b0, 1'b0, 1'b0, 8'd17};
`endif
        v[3] = {C_DIV, 16'd100,  16'd7,    32'h0002000E, 1'b0, 1'b0, 1'b0, 8'd17};
        v[4] = {C_DIV, 16'd5,    16'd0,    32'h0005FFFF, 1'b1, 1'b0, 1'b1, 8'd1};
        v[5] = {C_LSL, 16'h8001, 16'd17,   32'h00020000, 1'b1, 1'b0, 1'b0, 8'd1};
        v[6] = {C_LSR, 16'h0003, 16'd1,    32'h00000001, 1'b1, 1'b0, 1'b0, 8'd1};
        v[7] = {C_LSR, 16'h1234, 16'd40,   32'h00000000, 1'b0, 1'b1, 1'b0, 8'd1};
        for (int i = 0; i < 8; i++) begin
            sb.push_back(v[i].e);
            run_op(v[i].cmd, v[i].a, v[i].b, lat, bs, to);
            e = sb.pop_front();
            $display("vec[%0d] cmd=%0d a=%h b=%h lat=%0d out=%h CF=%b ZF=%b DZ=%b",
                     i, v[i].cmd, v[i].a, v[i].b, lat, bus.out, bus.CF, bus.ZF, bus.DZ);
            total++;
            if (to) begin
                bad++;
                $display("FAIL vec[%0d]_timeout: no done within %0d cycles", i, lat);
                continue;
            end
            if ({bus.out, bus.CF, bus.ZF, bus.DZ} !== {e.out, e.cf, e.zf, e.dz}) begin
                bad++;
                $display("FAIL vec[%0d]_result: out=%h CF=%b ZF=%b DZ=%b required out=%h CF=%b ZF=%b DZ=%b",
                         i, bus.out, bus.CF, bus.ZF, bus.DZ, e.out, e.cf, e.zf, e.dz);
            end
            total++;
            if (lat !== int'(e.lat)) begin
                bad++;
                $display("FAIL vec[%0d]_latency: %0d required %0d", i, lat, e.lat);
            end
            total++;
            if (bs !== (e.lat > 8'd1)) begin
                bad++;
                $display("FAIL vec[%0d]_busy: busy_seen=%b required %b", i, bs, e.lat > 8'd1);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] edge_amt[10];
        logic [2:0]   c;
        logic [W-1:0] a, b;
        exp_t         e;
        int           lat;
        bit           bs, to;
        edge_amt = '{16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd31, 16'd32, 16'd33, 16'd40, 16'hFFFF};
        for (int i = 0; i < 60; i++) begin
            c = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = 16'($urandom);
            if (c == C_LSL || c == C_LSR) b = edge_amt[$urandom_range(0, 9)];
            if (c == C_DIV && ($urandom_range(0, 4) == 0)) b = '0;
            if (c == C_MUL && ($urandom_range(0, 3) == 0)) b = 16'($urandom_range(0, 255));
            if (c == C_DIV && ($urandom_range(0, 3) == 0)) b = 16'($urandom_range(1, 20));
            sb.push_back(model(c, a, b));
            run_op(c, a, b, lat, bs, to);
            e = sb.pop_front();
            $display("rand[%0d] cmd=%0d a=%h b=%h lat=%0d out=%h CF=%b ZF=%b DZ=%b",
                     i, c, a, b, lat, bus.out, bus.CF, bus.ZF, bus.DZ);
            total++;
            if (to) begin
                bad++;
                $display("FAIL rand[%0d]_timeout: no done within %0d cycles", i, lat);
                continue;
            end
            if ({bus.out, bus.CF, bus.ZF, bus.DZ} !== {e.out, e.cf, e.zf, e.dz}) begin
                bad++;
                $display("FAIL rand[%0d]_result: out=%h CF=%b ZF=%b DZ=%b required out=%h CF=%b ZF=%b DZ=%b",
                         i, bus.out, bus.CF, bus.ZF, bus.DZ, e.out, e.cf, e.zf, e.dz);
            end
            total++;
            if (lat !== int'(e.lat)) begin
                bad++;
                $display("FAIL rand[%0d]_latency: %0d required %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   lat;
        bit   bs, to;
        sb.push_back(model(C_XOR, 16'hA5A5, 16'h0FF0));
        run_op(C_XOR, 16'hA5A5, 16'h0FF0, lat, bs, to);
        e = sb.pop_front();
        bus.cmd = C_ADD;
        bus.in1 = 16'h1111;
        bus.in2 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            $display("hold[%0d] done=%b out=%h", i, bus.done, bus.out);
            total++;
            if ({bus.done, bus.out} !== {1'b0, e.out}) begin
                bad++;
                $display("FAIL hold[%0d]: done=%b out=%h required done=0 out=%h", i, bus.done, bus.out, e.out);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        bit   got, bs, to;
        sb.push_back('{out: 32'h0001014D, cf: 1'b0, zf: 1'b0, dz: 1'b0, lat: 8'd17});
        bus.cmd   = C_DIV;
        bus.in1   = 16'd1000;
        bus.in2   = 16'd3;
        bus.start = 1'b1;
        lat       = 0;
        got       = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) got = 1'b1;
            if (lat == 3) begin
                // Presented for edge 4, while the divide is still running.
                bus.cmd   = C_ADD;
                bus.in1   = 16'd1;
                bus.in2   = 16'd2;
                bus.start = 1'b1;
            end
        end
        e = sb.pop_front();
        $display("busy_ignore: div lat=%0d out=%h", lat, bus.out);
        total++;
        if (!got || lat !== int'(e.lat) || bus.out !== e.out) begin
            bad++;
            $display("FAIL busy_ignore_div: got=%b lat=%0d out=%h required lat=%0d out=%h",
                     got, lat, bus.out, e.lat, e.out);
        end
        sb.push_back(model(C_ADD, 16'd1, 16'd2));
        run_op(C_ADD, 16'd1, 16'd2, lat, bs, to);
        e = sb.pop_front();
        $display("busy_ignore: add lat=%0d out=%h", lat, bus.out);
        total++;
        if (to || lat !== 1 || bus.out !== e.out) begin
            bad++;
            $display("FAIL busy_ignore_add: lat=%0d out=%h required lat=1 out=%h", lat, bus.out, e.out);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   cs[6];
        logic [W-1:0] as[6];
        logic [W-1:0] bs_[6];
        exp_t         e;
        cs  = '{C_ADD, C_XOR, C_DIV, C_LSR, C_AND, C_ADD};
        as  = '{16'h8000, 16'hFFFF, 16'h1234, 16'h8000, 16'hF0F0, 16'h0000};
        bs_ = '{16'h8000, 16'hFFFF, 16'h0000, 16'd16,   16'h0F0F, 16'h0000};
        bus.cmd   = cs[0];
        bus.in1   = as[0];
        bus.in2   = bs_[0];
        bus.start = 1'b1;
        sb.push_back(model(cs[0], as[0], bs_[0]));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            $display("b2b[%0d] done=%b out=%h CF=%b ZF=%b DZ=%b",
                     k, bus.done, bus.out, bus.CF, bus.ZF, bus.DZ);
            total++;
            if ({bus.done, bus.out, bus.CF, bus.ZF, bus.DZ} !== {1'b1, e.out, e.cf, e.zf, e.dz}) begin
                bad++;
                $display("FAIL b2b[%0d]: done=%b out=%h CF=%b ZF=%b DZ=%b required done=1 out=%h CF=%b ZF=%b DZ=%b",
                         k, bus.done, bus.out, bus.CF, bus.ZF, bus.DZ, e.out, e.cf, e.zf, e.dz);
            end
            if (k < 5) begin
                bus.cmd = cs[k+1];
                bus.in1 = as[k+1];
                bus.in2 = bs_[k+1];
                sb.push_back(model(cs[k+1], as[k+1], bs_[k+1]));
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        bit   bs, to, stray;
        bus.cmd   = C_MUL;
        bus.in1   = 16'hFFFF;
        bus.in2   = 16'hFFFF;
        bus.start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("reset_mid: busy=%b done=%b out=%h CF=%b ZF=%b DZ=%b",
                 bus.busy, bus.done, bus.out, bus.CF, bus.ZF, bus.DZ);
        total++;
        if ({bus.busy, bus.done, bus.out, bus.CF, bus.ZF, bus.DZ} !== 37'b0) begin
            bad++;
            $display("FAIL reset_mid_state: busy=%b done=%b out=%h CF=%b ZF=%b DZ=%b required all 0",
                     bus.busy, bus.done, bus.out, bus.CF, bus.ZF, bus.DZ);
        end
        rst_n = 1'b1;
        sb.push_back(model(C_ADD, 16'd2, 16'd3));
        run_op(C_ADD, 16'd2, 16'd3, lat, bs, to);
        e = sb.pop_front();
        $display("reset_mid: add lat=%0d out=%h", lat, bus.out);
        total++;
        if (to || lat !== 1 || bus.out !== e.out) begin
            bad++;
            $display("FAIL reset_mid_restart: lat=%0d out=%h required lat=1 out=%h", lat, bus.out, e.out);
        end
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL reset_mid_stray: aborted MUL still produced busy/done, required none");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
